// File: rtl/count_step_checker_if.sv
// Bus bundle between a step-counter monitor (slave) and whatever drives/observes it (master).
`timescale 1ns/1ps
interface count_step_checker_if #(
   parameter int BITS = 16
);
   logic [BITS-1:0] count;
   logic            sample_en;
   logic            clr_err;
   logic [1:0]      state;
   logic            locked;
   logic            err;
   logic [15:0]     err_count;
   logic [BITS-1:0] prev;

   modport master (
      output count, sample_en, clr_err,
      input  state, locked, err, err_count, prev
   );

   modport slave (
      input  count, sample_en, clr_err,
      output state, locked, err, err_count, prev
   );
endinterface

// File: rtl/count_step_checker.sv
// Monitors a step-down counter bus: locks onto a well-formed sequence, flags
// every step error while locked, tallies errors and drops lock after repeated faults.
`timescale 1ns/1ps
module count_step_checker #(
   parameter int BITS   = 16,
   parameter int STEP   = 10,
   parameter int LOCK_N = 4,
   parameter int LOSS_N = 3
) (
   input logic                   clk,
   input logic                   reset,
   count_step_checker_if.slave   bus
);
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   localparam logic [BITS-1:0] STEP_V    = BITS'(STEP);
   localparam logic [3:0]      LOCK_LAST = 4'(LOCK_N - 1);
   localparam logic [3:0]      LOSS_LAST = 4'(LOSS_N - 1);

   state_t          state_q, state_d;
   logic [BITS-1:0] prev_q, prev_d;
   logic [3:0]      good_run_q, good_run_d;
   logic [3:0]      bad_run_q, bad_run_d;
   logic [15:0]     err_count_q, err_count_d;
   logic            err_q, err_d;
   logic [BITS-1:0] expected;
   logic            match;
   logic [15:0]     err_base;

   assign expected = prev_q - STEP_V;
   assign match    = (bus.count == expected);
   // clr_err applies first, so a same-cycle error lands on a cleared tally.
   assign err_base = bus.clr_err ? 16'd0 : err_count_q;

   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      good_run_d  = good_run_q;
      bad_run_d   = bad_run_q;
      err_count_d = err_base;
      err_d       = 1'b0;

      if (bus.sample_en) begin
         prev_d = bus.count;
         case (state_q)
            ST_IDLE: begin
               good_run_d = 4'd0;
               state_d    = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
               if (match) begin
                  good_run_d = good_run_q + 4'd1;
                  if (good_run_q == LOCK_LAST) begin
                     state_d   = ST_LOCKED;
                     bad_run_d = 4'd0;
                  end
               end else begin
                  good_run_d = 4'd0;
               end
            end
            ST_LOCKED: begin
               if (match) begin
                  bad_run_d = 4'd0;
               end else begin
                  err_d     = 1'b1;
                  bad_run_d = bad_run_q + 4'd1;
                  if (err_base != 16'hFFFF) begin
                     err_count_d = err_base + 16'd1;
                  end
                  if (bad_run_q == LOSS_LAST) begin
                     state_d    = ST_ACQUIRE;
                     good_run_d = 4'd0;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         prev_q      <= '0;
         good_run_q  <= 4'd0;
         bad_run_q   <= 4'd0;
         err_count_q <= 16'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         good_run_q  <= good_run_d;
         bad_run_q   <= bad_run_d;
         err_count_q <= err_count_d;
         err_q       <= err_d;
      end
   end

   assign bus.state     = state_q;
   assign bus.locked    = (state_q == ST_LOCKED);
   assign bus.err       = err_q;
   assign bus.err_count = err_count_q;
   assign bus.prev      = prev_q;
endmodule

// File: tb/tb_count_step_checker.sv
// Bench for count_step_checker: fixed vector table, hand-built corner sequences
// and random samples checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_count_step_checker;
   logic clk = 1'b0;
   logic reset;

   count_step_checker_if #(.BITS(16)) bus();

   count_step_checker #(
      .BITS(16), .STEP(10), .LOCK_N(4), .LOSS_N(3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          en;
      bit          clr;
      logic [15:0] cnt;
      int          st;
      bit          err;
      int          ec;
      logic [15:0] prev;
   } vec_t;

   vec_t vq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // reference model: plain integers following the sample rules
   int          m_state, m_good, m_bad, m_ec;
   bit          m_err;
   logic [15:0] m_prev;

   task automatic model_reset();
      m_state = 0; m_good = 0; m_bad = 0; m_ec = 0; m_err = 0; m_prev = 16'd0;
   endtask

   task automatic model_step(input bit en, input bit clr, input logic [15:0] cnt);
      logic [15:0] want;
      want  = 16'((int'(m_prev) - 10 + 65536) % 65536);
      m_err = 0;
      if (clr) m_ec = 0;
      if (en) begin
         if (m_state == 0) begin
            m_state = 1; m_good = 0;
         end else if (m_state == 1) begin
            if (cnt == want) begin
               m_good++;
               if (m_good == 4) begin m_state = 2; m_bad = 0; end
            end else begin
               m_good = 0;
            end
         end else begin
            if (cnt == want) begin
               m_bad = 0;
            end else begin
               m_err = 1;
               if (m_ec < 65535) m_ec++;
               m_bad++;
               if (m_bad == 3) begin m_state = 1; m_good = 0; end
            end
         end
         m_prev = cnt;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, " state"},     32'(bus.state),     32'(m_state));
      chk({tag, " locked"},    32'(bus.locked),    32'(m_state == 2));
      chk({tag, " err"},       32'(bus.err),       32'(m_err));
      chk({tag, " err_count"}, 32'(bus.err_count), 32'(m_ec));
      chk({tag, " prev"},      32'(bus.prev),      32'(m_prev));
   endtask

   task automatic step(input bit en, input bit clr, input logic [15:0] cnt);
      @(negedge clk);
      bus.sample_en = en;
      bus.clr_err   = clr;
      bus.count     = cnt;
      @(posedge clk);
      model_step(en, clr, cnt);
      #1;
      $display("step en=%0d clr=%0d count=%h -> state=%0d err=%0d err_count=%h prev=%h",
               en, clr, cnt, bus.state, bus.err, bus.err_count, bus.prev);
   endtask

   initial begin
      // {en, clr, count, state, err, err_count, prev}
      vq.push_back('{1, 0, 16'd100,   1, 0, 0, 16'd100});
      vq.push_back('{1, 0, 16'd90,    1, 0, 0, 16'd90});
      vq.push_back('{1, 0, 16'd80,    1, 0, 0, 16'd80});
      vq.push_back('{1, 0, 16'd70,    1, 0, 0, 16'd70});
      vq.push_back('{1, 0, 16'd60,    2, 0, 0, 16'd60});
      vq.push_back('{1, 0, 16'd50,    2, 0, 0, 16'd50});
      vq.push_back('{1, 0, 16'd40,    2, 0, 0, 16'd40});
      vq.push_back('{1, 0, 16'd30,    2, 0, 0, 16'd30});
      vq.push_back('{1, 0, 16'd20,    2, 0, 0, 16'd20});
      vq.push_back('{1, 0, 16'd10,    2, 0, 0, 16'd10});
      vq.push_back('{1, 0, 16'd0,     2, 0, 0, 16'd0});
      vq.push_back('{1, 0, 16'hFFF6,  2, 0, 0, 16'hFFF6});
      vq.push_back('{1, 0, 16'hFFEC,  2, 0, 0, 16'hFFEC});
      vq.push_back('{1, 0, 16'd55,    2, 1, 1, 16'd55});
      vq.push_back('{1, 0, 16'd45,    2, 0, 1, 16'd45});
      vq.push_back('{1, 0, 16'd35,    2, 0, 1, 16'd35});
      vq.push_back('{1, 0, 16'd7,     2, 1, 2, 16'd7});
      vq.push_back('{1, 0, 16'd7,     2, 1, 3, 16'd7});
      vq.push_back('{1, 0, 16'd7,     1, 1, 4, 16'd7});
      vq.push_back('{0, 0, 16'hFFFD,  1, 0, 4, 16'd7});
      vq.push_back('{0, 0, 16'd1,     1, 0, 4, 16'd7});
      vq.push_back('{0, 0, 16'd2,     1, 0, 4, 16'd7});
      vq.push_back('{0, 0, 16'd3,     1, 0, 4, 16'd7});
      vq.push_back('{0, 0, 16'd4,     1, 0, 4, 16'd7});
      vq.push_back('{1, 0, 16'hFFFD,  1, 0, 4, 16'hFFFD});
      vq.push_back('{1, 0, 16'hFFF3,  1, 0, 4, 16'hFFF3});
      vq.push_back('{1, 0, 16'hFFE9,  1, 0, 4, 16'hFFE9});
      vq.push_back('{1, 0, 16'hFFDF,  2, 0, 4, 16'hFFDF});
      vq.push_back('{1, 1, 16'h1234,  2, 1, 1, 16'h1234});
      vq.push_back('{0, 1, 16'h0000,  2, 0, 0, 16'h1234});
      vq.push_back('{1, 0, 16'h122A,  2, 0, 0, 16'h122A});
      vq.push_back('{1, 0, 16'd0,     2, 1, 1, 16'd0});
      vq.push_back('{1, 0, 16'hFFF6,  2, 0, 1, 16'hFFF6});

      bus.count = 16'd0; bus.sample_en = 1'b0; bus.clr_err = 1'b0;
      reset = 1'b1;
      model_reset();
      #12;
      chk("reset state",     32'(bus.state),     32'd0);
      chk("reset locked",    32'(bus.locked),    32'd0);
      chk("reset err",       32'(bus.err),       32'd0);
      chk("reset err_count", 32'(bus.err_count), 32'd0);
      chk("reset prev",      32'(bus.prev),      32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         step(vq[i].en, vq[i].clr, vq[i].cnt);
         chk($sformatf("vec%0d state", i),     32'(bus.state),     32'(vq[i].st));
         chk($sformatf("vec%0d locked", i),    32'(bus.locked),    32'(vq[i].st == 2));
         chk($sformatf("vec%0d err", i),       32'(bus.err),       32'(vq[i].err));
         chk($sformatf("vec%0d err_count", i), 32'(bus.err_count), 32'(vq[i].ec));
         chk($sformatf("vec%0d prev", i),      32'(bus.prev),      32'(vq[i].prev));
      end
      chk_model("model sync");

      // saturation: preload the tally just below the ceiling
      @(negedge clk);
      bus.sample_en = 1'b0; bus.clr_err = 1'b0;
      force dut.err_count_q = 16'hFFFD;
      @(posedge clk);
      @(negedge clk);
      release dut.err_count_q;
      m_ec = 65533; m_err = 0;
      chk("sat preload", 32'(bus.err_count), 32'h0000FFFD);
      step(1, 0, 16'h1111); chk_model("sat1");
      step(1, 0, 16'h2222); chk_model("sat2");
      chk("sat at max", 32'(bus.err_count), 32'h0000FFFF);
      step(1, 0, 16'h2218); chk_model("sat match");
      step(1, 0, 16'h0005); chk_model("sat hold");
      chk("sat hold value", 32'(bus.err_count), 32'h0000FFFF);

      // asynchronous reset between clock edges
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      model_reset();
      chk_model("async reset");
      @(negedge clk);
      reset = 1'b0;
      step(1, 0, 16'd500); chk_model("post reset capture");

      // random mix of matches, glitches, stalls and clears
      for (int i = 0; i < 400; i++) begin
         bit          en, clr;
         logic [15:0] c;
         en  = ($urandom_range(0, 9) < 8);
         clr = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0) c = 16'($urandom);
         else c = 16'((int'(m_prev) - 10 + 65536) % 65536);
         step(en, clr, c);
         chk_model($sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
